eth_tx_arbiter: RTL
===================

Name: eth_tx_arbiter

Overview:
Packet-level round-robin arbiter that shares the single 8-bit ETH_TX AXI-Stream input of rmii_ethernet between two frame sources, such as a test-frame generator and a loopback or reply path. A grant lasts for exactly one frame, from grant until the TLAST handshake. A programmable idle gap is enforced between consecutive forwarded frames. The block sits in the clk100 domain, directly upstream of the MAC's ETH_TX_AXIS_* port.

Parameters:
DATA_WIDTH, 8, tdata width of all streams.
GAP_CYCLES, 12, clocks of forced idle after each forwarded frame's TLAST handshake (0 = no gap state).
CNT_WIDTH, 16, width of the per-port frame counters.

Ports:
CLK  in  1  clock (clk100 domain); all logic on the rising edge.
RESETN  in  1  synchronous reset, active-low.
S0_AXIS_TDATA  in  DATA_WIDTH  source 0 data.
S0_AXIS_TVALID  in  1  source 0 valid.
S0_AXIS_TLAST  in  1  source 0 end of frame.
S0_AXIS_TREADY  out  1  source 0 ready.
S1_AXIS_TDATA  in  DATA_WIDTH  source 1 data.
S1_AXIS_TVALID  in  1  source 1 valid.
S1_AXIS_TLAST  in  1  source 1 end of frame.
S1_AXIS_TREADY  out  1  source 1 ready.
M_AXIS_TDATA  out  DATA_WIDTH  to ETH_TX_AXIS_TDATA.
M_AXIS_TVALID  out  1  to ETH_TX_AXIS_TVALID.
M_AXIS_TLAST  out  1  to ETH_TX_AXIS_TLAST.
M_AXIS_TREADY  in  1  from ETH_TX_AXIS_TREADY.
GRANT  out  2  one-hot current owner; 00 when no owner.
BUSY  out  1  high in XFER or GAP.
FRAME_CNT0  out  CNT_WIDTH  frames forwarded from source 0.
FRAME_CNT1  out  CNT_WIDTH  frames forwarded from source 1.

Behaviour:
- Clock and reset: single clock CLK; synchronous, active-low reset RESETN, sampled on the CLK rising edge.
- Reset (RESETN=0 at a clock edge):
  - state=IDLE; GRANT=00; last_owner=1, so port 0 wins first.
  - Gap counter=0; FRAME_CNT0/1=0.
  - All TREADY=0; M_AXIS_TVALID=0, TLAST=0, TDATA=0.
- FSM states: IDLE, XFER, GAP; state and GRANT are registered.
- IDLE:
  - No handshakes are accepted; all TREADY=0, M_AXIS_TVALID=0.
  - If any Sx_TVALID=1: grant the requester that is not last_owner if it is requesting, otherwise the other requester.
  - Next cycle: state=XFER, GRANT one-hot, last_owner=winner.
  - Latency: Sx_TVALID rising in IDLE gives M_AXIS_TVALID one cycle later.
- XFER (owner k):
  - Combinational pass-through: M_AXIS_TDATA/TVALID/TLAST = Sk_*; Sk_TREADY = M_AXIS_TREADY; the other TREADY=0.
  - Zero added latency; back-pressure propagates in the same cycle.
- Frame end in XFER: on M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST:
  - FRAME_CNTk increments, wrapping modulo 2^CNT_WIDTH.
  - If GAP_CYCLES=0: state=IDLE, GRANT=00.
  - Otherwise: state=GAP, GRANT=00, gap counter loaded with GAP_CYCLES-1.
- Single-beat frame (TLAST on the first beat): legal; handled identically.
- GAP:
  - All TREADY=0, M_AXIS_TVALID=0.
  - Counter decrements each cycle; at 0, state=IDLE.
  - GAP therefore lasts exactly GAP_CYCLES cycles.
- Frame spacing: minimum spacing between the last beat of one frame and the first M_AXIS_TVALID of the next is GAP_CYCLES+1 idle cycles (GAP plus the IDLE arbitration cycle).
- Ownership rules:
  - The non-owner's TVALID is ignored for the whole frame, which is never interleaved.
  - The owner dropping TVALID mid-frame keeps the grant; M_AXIS_TVALID follows it low.
- Simultaneous requests in IDLE: strict alternation. Both sources continuously valid yields frames in the order 0,1,0,1,...
- Reset mid-frame or mid-gap: immediate return to the reset state at that edge, without completing the frame. Sources and MAC are reset by the same RESETN domain.
- Outputs when not in XFER: M_AXIS_TDATA and M_AXIS_TLAST are forced to 0.
- BUSY = (state != IDLE).

Test Plan:
- Reset release, then S0 sends a 4-beat frame 0x11..0x14 with M_TREADY=1 → M_TVALID rises 1 cycle after S0_TVALID; bytes 0x11..0x14 in order; TLAST on 0x14; FRAME_CNT0=1; GRANT 01→00; BUSY high for 4+12 cycles.
- S0 and S1 both continuously valid with 3-beat frames → output order S0,S1,S0,S1; each inter-frame gap exactly 13 idle cycles; counters 2/2 after 4 frames.
- M_TREADY toggling 1,0,1,0 during an S1 frame → S1_TREADY mirrors it cycle-for-cycle; S0_TREADY=0 throughout; no beat duplicated or lost.
- Single-beat frame from S0 with GAP_CYCLES=0 (separate elaboration) → IDLE next cycle; next S1 frame's M_TVALID appears 2 cycles after the S0 TLAST handshake.
- RESETN=0 on the 2nd beat of an S0 frame → on the next edge: GRANT=00, all TREADY=0, M_TVALID=0, counters=0; after release, first grant goes to S0.
- FRAME_CNT0 preloaded by forcing 0xFFFF, then one S0 frame → wraps to 0x0000.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// ----------------------------------------------------------------------------
// eth_tx_arbiter
//
// Packet-level round-robin arbiter that shares the single 8-bit ETH_TX
// AXI-Stream input of the MAC between two frame sources. Ownership is granted
// for exactly one frame (grant .. TLAST handshake). After every forwarded
// frame a programmable idle gap is enforced before the next arbitration.
//
// Ports:
//   CLK               clock, all logic on the rising edge
//   RESETN            synchronous reset, active-low
//   S0_AXIS_*         source 0 stream (TDATA/TVALID/TLAST in, TREADY out)
//   S1_AXIS_*         source 1 stream (TDATA/TVALID/TLAST in, TREADY out)
//   M_AXIS_*          merged stream towards the MAC (TREADY in)
//   GRANT             one-hot current owner, 00 when nobody owns the bus
//   BUSY              high while a frame is forwarded or the gap runs
//   FRAME_CNT0/1      frames forwarded from source 0/1 (wrapping)
// ----------------------------------------------------------------------------
module eth_tx_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RESETN,

    input  logic [DATA_WIDTH-1:0] S0_AXIS_TDATA,
    input  logic                  S0_AXIS_TVALID,
    input  logic                  S0_AXIS_TLAST,
    output logic                  S0_AXIS_TREADY,

    input  logic [DATA_WIDTH-1:0] S1_AXIS_TDATA,
    input  logic                  S1_AXIS_TVALID,
    input  logic                  S1_AXIS_TLAST,
    output logic                  S1_AXIS_TREADY,

    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TVALID,
    output logic                  M_AXIS_TLAST,
    input  logic                  M_AXIS_TREADY,

    output logic [1:0]            GRANT,
    output logic                  BUSY,
    output logic [CNT_WIDTH-1:0]  FRAME_CNT0,
    output logic [CNT_WIDTH-1:0]  FRAME_CNT1
);

    // Gap counter is loaded with GAP_CYCLES-1 and counts down to zero, so it
    // only needs to hold values up to GAP_CYCLES-1.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD =
        GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               state_reg;
    logic [1:0]           grant_reg;
    logic                 last_owner_reg;
    logic [GAP_W-1:0]     gap_cnt_reg;
    logic [CNT_WIDTH-1:0] frame_cnt0_reg;
    logic [CNT_WIDTH-1:0] frame_cnt1_reg;

    // Per-port views so the datapath can be written once for both sources.
    logic [DATA_WIDTH-1:0] s_tdata  [2];
    logic                  s_tvalid [2];
    logic                  s_tlast  [2];
    logic                  s_tready [2];

    assign s_tdata[0]  = S0_AXIS_TDATA;
    assign s_tdata[1]  = S1_AXIS_TDATA;
    assign s_tvalid[0] = S0_AXIS_TVALID;
    assign s_tvalid[1] = S1_AXIS_TVALID;
    assign s_tlast[0]  = S0_AXIS_TLAST;
    assign s_tlast[1]  = S1_AXIS_TLAST;

    logic xfer;
    logic owner;
    logic winner;
    logic any_req;
    logic frame_end;

    logic [DATA_WIDTH-1:0] m_tdata_mux;
    logic                  m_tvalid_mux;
    logic                  m_tlast_mux;

    assign xfer  = (state_reg == ST_XFER);
    // grant_reg is one-hot while in XFER, so bit 1 is the owner index.
    assign owner = grant_reg[1];

    // Prefer the source that did not own the previous frame; fall back to
    // the other one when the preferred source is not requesting.
    assign any_req = S0_AXIS_TVALID | S1_AXIS_TVALID;
    assign winner  = last_owner_reg ? ~S0_AXIS_TVALID : S1_AXIS_TVALID;

    // Zero-latency pass-through of the owner; everything is forced to zero
    // outside XFER so the MAC never sees stale data or a stray TLAST.
    always_comb begin
        m_tdata_mux  = '0;
        m_tvalid_mux = 1'b0;
        m_tlast_mux  = 1'b0;
        if (xfer) begin
            m_tdata_mux  = s_tdata[owner];
            m_tvalid_mux = s_tvalid[owner];
            m_tlast_mux  = s_tlast[owner];
        end
    end

    // Back-pressure goes straight to the owner only; grant_reg is zero
    // outside XFER, which keeps every TREADY low in IDLE and GAP.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign s_tready[gi] = grant_reg[gi] & M_AXIS_TREADY;
        end
    endgenerate

    assign frame_end = xfer & m_tvalid_mux & M_AXIS_TREADY & m_tlast_mux;

    // ------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= 2'b00;
            last_owner_reg <= 1'b1;
            gap_cnt_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        state_reg      <= ST_XFER;
                        grant_reg      <= winner ? 2'b10 : 2'b01;
                        last_owner_reg <= winner;
                    end
                end

                ST_XFER: begin
                    if (frame_end) begin
                        grant_reg <= 2'b00;
                        if (GAP_CYCLES == 0) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg   <= ST_GAP;
                            gap_cnt_reg <= GAP_LOAD;
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_cnt_reg == '0) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    grant_reg <= 2'b00;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Per-source frame counters, bumped on the TLAST handshake
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            frame_cnt0_reg <= '0;
            frame_cnt1_reg <= '0;
        end else begin
            if (frame_end && !owner) begin
                frame_cnt0_reg <= frame_cnt0_reg + CNT_WIDTH'(1);
            end
            if (frame_end && owner) begin
                frame_cnt1_reg <= frame_cnt1_reg + CNT_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign M_AXIS_TDATA   = m_tdata_mux;
    assign M_AXIS_TVALID  = m_tvalid_mux;
    assign M_AXIS_TLAST   = m_tlast_mux;
    assign S0_AXIS_TREADY = s_tready[0];
    assign S1_AXIS_TREADY = s_tready[1];
    assign GRANT          = grant_reg;
    assign BUSY           = (state_reg != ST_IDLE);
    assign FRAME_CNT0     = frame_cnt0_reg;
    assign FRAME_CNT1     = frame_cnt1_reg;

endmodule
